regfile_loader: RTL and testbench

Front-end controller for the 16x8 register file and its min/sum scan engine. It accepts a frame of 16 bytes over a valid/ready stream and writes them into the register file at addresses 0..15. It then pulses `go` to the scan engine, waits for `done`, captures the engine's `min`/`sum`, and offers them on a result valid/ready port. This block is the writer side of the register-file interface; the scan engine is the reader.

---
 rtl/regfile_loader.sv | 180 ++++++++++++++++++
 tb/tb_regfile_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_loader
//  Purpose  : Front-end controller for a DEPTH x WIDTH register file and its
//             min/sum scan engine. It takes one frame of DEPTH bytes from a
//             valid/ready stream and writes it to addresses 0..DEPTH-1. It
//             then pulses go to the engine and waits for a rising edge on
//             done. The engine's min/sum results are captured and offered on
//             a result valid/ready port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   1       clock, rising edge active
//    rst_ni       in   1       asynchronous reset, active low
//    in_valid_i   in   1       input byte valid
//    in_data_i    in   WIDTH   input byte
//    in_ready_o   out  1       byte can be accepted this cycle
//    w_en_o       out  1       register-file write enable (registered)
//    w_addr_o     out  ADDR_W  register-file write address
//    w_data_o     out  WIDTH   register-file write data
//    go_o         out  1       single-cycle start pulse to scan engine
//    done_i       in   1       engine finished (level, rising edge used)
//    min_in_i     in   RES_W   engine minimum, valid while done_i high
//    sum_in_i     in   RES_W   engine sum, valid while done_i high
//    res_valid_o  out  1       captured result available
//    res_ready_i  in   1       consumer takes the result
//    res_min_o    out  RES_W   captured minimum
//    res_sum_o    out  RES_W   captured sum
//    busy_o       out  1       low only when idle in LOAD with count 0
// ============================================================================
module regfile_loader #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int RES_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              in_ready_o,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [WIDTH-1:0]  w_data_o,
  output logic              go_o,
  input  logic              done_i,
  input  logic [RES_W-1:0]  min_in_i,
  input  logic [RES_W-1:0]  sum_in_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [RES_W-1:0]  res_min_o,
  output logic [RES_W-1:0]  res_sum_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FLUSH  = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic               done_q;
  logic               arm_q;
  logic               w_en_q, w_en_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [WIDTH-1:0]   w_data_q, w_data_d;
  logic [RES_W-1:0]   res_min_q, res_min_d;
  logic [RES_W-1:0]   res_sum_q, res_sum_d;
  logic               accept;
  logic               done_rise;

  // arm_q keeps in_ready low while reset is asserted and releases it on the
  // first clock edge after reset deasserts, so the reset net never feeds
  // synchronous logic directly.
  assign in_ready_o = (state_q == S_LOAD) && arm_q;
  assign accept     = in_valid_i && in_ready_o;

  // Only a fresh rising edge counts; a done level left high by the previous
  // frame is filtered out because done_q is already high.
  assign done_rise  = done_i && !done_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_LOAD;
      count_q   <= '0;
      done_q    <= 1'b0;
      arm_q     <= 1'b0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      res_min_q <= '0;
      res_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_i;
      arm_q     <= 1'b1;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      res_min_q <= res_min_d;
      res_sum_q <= res_sum_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    w_en_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    res_min_d = res_min_q;
    res_sum_d = res_sum_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          // Accepted byte goes into the write stage; it shows on the bus
          // in the following cycle.
          w_en_d   = 1'b1;
          w_addr_d = count_q;
          w_data_d = in_data_i;
          // count wraps to 0 naturally after the last entry.
          count_d  = count_q + ADDR_W'(1);
          if (count_q == LAST_IDX) begin
            state_d = S_FLUSH;
          end
        end
      end

      // Last write is on the bus during FLUSH; go follows in START so the
      // engine never sees go alongside a pending write.
      S_FLUSH: state_d = S_START;

      S_START: state_d = S_WAIT;

      S_WAIT: begin
        if (done_rise) begin
          res_min_d = min_in_i;
          res_sum_d = sum_in_i;
          state_d   = S_RESULT;
        end
      end

      S_RESULT: begin
        if (res_ready_i) begin
          state_d = S_LOAD;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_en_o      = w_en_q;
  assign w_addr_o    = w_addr_q;
  assign w_data_o    = w_data_q;
  assign go_o        = (state_q == S_START);
  assign res_valid_o = (state_q == S_RESULT);
  assign res_min_o   = res_min_q;
  assign res_sum_o   = res_sum_q;
  assign busy_o      = !((state_q == S_LOAD) && (count_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_regfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_loader
//  Purpose  : Self-checking bench for regfile_loader. A frame-level model
//             (bytes loaded, cycles since the frame completed, pending
//             result) predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_loader;

  logic       clk;
  logic       rst_n;
  logic       iv;
  logic [7:0] id;
  logic       in_ready_o;
  logic       w_en_o;
  logic [3:0] w_addr_o;
  logic [7:0] w_data_o;
  logic       go_o;
  logic       done;
  logic [8:0] min_v;
  logic [8:0] sum_v;
  logic       res_valid_o;
  logic       rr;
  logic [8:0] res_min_o;
  logic [8:0] res_sum_o;
  logic       busy_o;

  regfile_loader #(
    .DEPTH(16), .WIDTH(8), .ADDR_W(4), .RES_W(9)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (iv),
    .in_data_i  (id),
    .in_ready_o (in_ready_o),
    .w_en_o     (w_en_o),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o),
    .go_o       (go_o),
    .done_i     (done),
    .min_in_i   (min_v),
    .sum_in_i   (sum_v),
    .res_valid_o(res_valid_o),
    .res_ready_i(rr),
    .res_min_o  (res_min_o),
    .res_sum_o  (res_sum_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Frame-level reference model
  int         m_loaded;    // bytes accepted this frame (0..16)
  int         m_after;     // cycles since the 16th byte was accepted
  bit         m_have;      // result captured and not yet taken
  bit         m_wen;
  bit         m_done_prev; // done as seen at the previous edge
  logic [3:0] m_addr;
  logic [7:0] m_data;
  logic [8:0] m_min;
  logic [8:0] m_sum;
  int         nwr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_loaded = 0; m_after = 0; m_have = 0; m_wen = 0; m_done_prev = 0;
    m_addr = '0; m_data = '0; m_min = '0; m_sum = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_w_en",      w_en_o, 0);
    chk("rst_go",        go_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_busy",      busy_o, 0);
    chk("rst_w_addr",    w_addr_o, 0);
    chk("rst_w_data",    w_data_o, 0);
    chk("rst_res_min",   res_min_o, 0);
    chk("rst_res_sum",   res_sum_o, 0);
    chk("rst_in_ready",  in_ready_o, 0);
  endtask

  // Release reset away from the edge, then let one edge pass with idle input.
  task automatic release_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_done_prev = done;
  endtask

  // Assert reset mid-cycle and check that it acts without a clock edge.
  task automatic do_reset();
    iv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    release_reset();
  endtask

  // One clock cycle: inputs were set by the caller just after the last edge.
  task automatic step();
    bit acc, cap, hs, prev16;
    @(negedge clk);
    chk("in_ready", in_ready_o, m_loaded < 16);
    acc = iv && (m_loaded < 16);
    cap = (m_loaded == 16) && (m_after >= 3) && !m_have && done && !m_done_prev;
    hs  = m_have && rr;
    @(posedge clk); #1;
    prev16      = (m_loaded == 16);
    m_done_prev = done;
    m_wen       = acc;
    if (acc) begin
      m_addr = 4'(m_loaded);
      m_data = id;
      m_loaded++;
      if (m_loaded == 16) m_after = 1;
    end else if (prev16 && m_after < 1000) begin
      m_after++;
    end
    if (cap) begin
      m_have = 1'b1; m_min = min_v; m_sum = sum_v;
    end
    if (hs) begin
      m_have = 1'b0; m_loaded = 0; m_after = 0;
    end
    if (w_en_o) nwr++;
    chk("w_en",      w_en_o, m_wen);
    chk("w_addr",    w_addr_o, m_addr);
    chk("w_data",    w_data_o, m_data);
    chk("go",        go_o, (m_loaded == 16) && (m_after == 2));
    chk("res_valid", res_valid_o, m_have);
    chk("busy",      busy_o, m_loaded != 0);
    if (m_have) begin
      chk("res_min", res_min_o, m_min);
      chk("res_sum", res_sum_o, m_sum);
    end
  endtask

  // mode 0: continuous 0x10.., mode 1: every other cycle, mode 2: random
  task automatic load_frame(input int mode);
    nwr = 0;
    for (int k = 0; k < 400 && m_loaded < 16; k++) begin
      case (mode)
        0:       iv = 1'b1;
        1:       iv = (k % 2 == 1);
        default: iv = 1'($urandom % 2);
      endcase
      id = (mode == 0) ? 8'(8'h10 + m_loaded) : 8'($urandom);
      step();
    end
    // Input stays valid during FLUSH and must be ignored.
    iv = 1'b1;
    id = 8'($urandom);
    step();
    chk("frame_writes", nwr, 16);
  endtask

  task automatic get_result(input int stale, input int lo, input bit rr_early,
                            input int hold, input logic [8:0] mn, input logic [8:0] sm);
    iv = 1'b1;
    id = 8'($urandom);
    rr = rr_early;
    repeat (stale) step();
    done = 1'b0;
    repeat (lo) step();
    done  = 1'b1;
    min_v = mn;
    sum_v = sm;
    for (int k = 0; k < 50 && !m_have; k++) step();
    chk("res_valid_after_done", res_valid_o, !rr_early || m_have);
    if (!rr_early) begin
      rr = 1'b0;
      min_v = 9'($urandom);
      sum_v = 9'($urandom);
      repeat (hold) step();
    end
    rr = 1'b1;
    for (int k = 0; k < 50 && m_have; k++) step();
    chk("res_released", res_valid_o, 0);
    iv = 1'b0;
    rr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 1'b0; id = '0; done = 1'b0; rr = 1'b0; min_v = '0; sum_v = '0;
    model_reset();
    #1;
    chk_reset_outputs();
    release_reset();

    // Full frame, continuous stream, then result capture with a stall.
    load_frame(0);
    get_result(2, 5, 1'b0, 4, 9'h010, 9'h1F8);

    // done stays high from the previous frame; gapped input stream.
    load_frame(1);
    get_result(6, 1, 1'b0, 2, 9'($urandom), 9'($urandom));

    // Reset in the middle of a frame.
    iv = 1'b1;
    repeat (7) begin
      id = 8'($urandom);
      step();
    end
    do_reset();
    load_frame(2);
    get_result(2, 3, 1'b1, 0, 9'($urandom), 9'($urandom));

    // Randomised frames.
    for (int r = 0; r < 3; r++) begin
      load_frame(2);
      get_result(2 + int'($urandom % 3), 1 + int'($urandom % 4), 1'($urandom % 2),
                 int'($urandom % 4), 9'($urandom), 9'($urandom));
    end

    // First accept right after the last handshake.
    iv = 1'b1;
    id = 8'($urandom);
    step();
    iv = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
